uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//   UART receiver front end (8N1, LSB first) that feeds the SHA-256 UART command path.
//   Synchronises the asynchronous rx pin and validates the start bit at mid-bit.
//   Samples 8 data bits and checks the stop bit.
//   Emits each good byte as a one-cycle rx_valid pulse with rx_data held stable.
//   Bad stop bits are reported on frame_err instead of producing data.
// PARAMETERS
//   BAUD_DIV   868   clk cycles per bit (CLK_FREQ/BAUD); legal range >= 4
//   HALF       BAUD_DIV/2 (localparam, integer divide)   mid-bit offset
// PORTS
//   clk        in   1   single system clock
//   rst        in   1   synchronous, active-high reset
//   rx         in   1   asynchronous serial line, idle high
//   rx_data    out  8   last good byte; holds its value until the next good byte
//   rx_valid   out  1   one-cycle pulse: rx_data is updated and valid
//   frame_err  out  1   one-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//   Reset (sync, at the clk edge with rst=1)
//     - state=IDLE; counters 0; shift reg 0.
//     - rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
//     - Both sync flops set to 1 (line idle).
//     - rst mid-frame aborts the frame silently; no pulse is produced.
//   Synchroniser: two flops, rx -> rx_m -> rx_s. All decisions use rx_s only.
//   States: IDLE, START, DATA, STOP, BREAK. Bit-time counter cnt is 16 bits wide.
//   IDLE
//     - On rx_s==0: go to START, cnt<=0. Call this cycle t0.
//   START
//     - cnt increments each cycle.
//     - When cnt==HALF-1 (cycle t0+HALF):
//       - rx_s==0: go to DATA, cnt<=0, bitn<=0.
//       - rx_s==1: glitch; go to IDLE, no output.
//   DATA
//     - At cnt==BAUD_DIV-1: shreg <= {rx_s, shreg[7:1]}, cnt<=0, bitn++.
//     - After the 8th sample, go to STOP.
//     - Bit i (0..7) is sampled at t0+HALF+(i+1)*BAUD_DIV.
//   STOP
//     - At cnt==BAUD_DIV-1 (cycle ts = t0+HALF+9*BAUD_DIV):
//       - rx_s==1: rx_data<=shreg; rx_valid=1 in cycle ts+1 only; go to IDLE.
//       - rx_s==0: frame_err=1 in cycle ts+1 only; rx_data unchanged; go to BREAK.
//   BREAK
//     - Stay until rx_s==1, then go to IDLE.
//     - A held-low line yields exactly one frame_err and no further start bits.
//   Pulse rules
//     - rx_valid and frame_err are registered, mutually exclusive, never high 2 cycles running.
//     - There is no ready/backpressure. The consumer must take the byte in the pulse cycle.
//   Back-to-back frames
//     - STOP returns to IDLE at mid-stop-bit.
//     - A start edge arriving right after a 1-bit stop is caught with no lost byte.
//   Timing tolerance: edge-to-mid-bit slack of HALF cycles tolerates roughly +/-4% baud mismatch.
// TESTING (sim BAUD_DIV=16, HALF=8, ideal 16-cycle bits)
//   1. Send 8'h01 then 8'hFF (command start + terminator).
//      -> Two rx_valid pulses; rx_data=01, then FF; frame_err never high.
//   2. Send 8'hA5.
//      -> rx_valid exactly t0+8+144+1 cycles after t0 (t0 = first cycle rx_s is low in IDLE).
//      -> rx_data=A5; busy high from t0+1 through the pulse cycle.
//   3. Drive rx low for 3 cycles in IDLE.
//      -> START rejects the glitch at t0+8; no rx_valid or frame_err; busy falls after 9 cycles.
//   4. Send 8'h3C with the stop bit low, holding rx low for 40 more cycles, then high.
//      -> Exactly one frame_err pulse; rx_data keeps its prior value.
//      -> A following 8'h55 is received correctly.
//   5. Send 8'h12, 8'h34, 8'h56 back-to-back with 1-bit stops.
//      -> Three rx_valid pulses in order; pulse spacing 160 cycles.
//   6. Assert rst for 1 cycle during bit 4 of 8'hC3, then send 8'h7E.
//      -> No output for C3; all outputs at reset values next cycle; 7E received.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receive front end: two-flop synchroniser, mid-bit start validation,
// LSB-first data capture and stop-bit check with one-cycle result pulses.
module uart_rx_sampler #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = BAUD_DIV / 2;
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
  localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              bitn  <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BAUD_M1) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= '0;
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          // busy stays high through the pulse cycle; IDLE clears it next edge
          if (cnt == BAUD_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at BAUD_DIV=16 with ideal 16-cycle bits.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] vq[$];
  int         vt[$];
  int fe_cnt = 0, fe_t = 0, both_cnt = 0, dbl_cnt = 0, rise_t = 0, fall_t = 0;
  logic pv = 1'b0, pf = 1'b0, pb = 1'b0;
  int e0;
  int found;
  logic [7:0] b;

  uart_rx_sampler #(.BAUD_DIV(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc seen here is the index of the edge that produced the sampled outputs
  always @(negedge clk) begin
    if (rx_valid) begin vq.push_back(rx_data); vt.push_back(cyc); end
    if (frame_err) begin fe_cnt++; fe_t = cyc; end
    if (rx_valid && frame_err) both_cnt++;
    if ((rx_valid && pv) || (frame_err && pf)) dbl_cnt++;
    if (busy && !pb) rise_t = cyc;
    if (!busy && pb) fall_t = cyc;
    pv = rx_valid; pf = frame_err; pb = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = stop;
    tick(16);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(4);

    // two frames back to back
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(4);
    check("t1_count", vq.size(), 2);
    check("t1_byte0", vq[0], 8'h01);
    check("t1_byte1", vq[1], 8'hFF);
    check("t1_no_ferr", fe_cnt, 0);

    // latency and busy window of one frame
    vq.delete(); vt.delete();
    tick(5);
    e0 = cyc;
    send_byte(8'hA5, 1'b1);
    tick(4);
    check("t2_count", vq.size(), 1);
    check("t2_data", vq[0], 8'hA5);
    check("t2_latency", vt[0] - e0, 155);
    check("t2_busy_rise", rise_t - e0, 3);
    check("t2_busy_fall", fall_t - e0, 156);
    check("t2_rx_data_hold", rx_data, 8'hA5);

    // 3-cycle glitch rejected at mid start bit
    vq.delete(); vt.delete();
    tick(5);
    e0 = cyc;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("t3_busy_rise", rise_t - e0, 3);
    check("t3_busy_fall", fall_t - e0, 11);
    check("t3_no_valid", vq.size(), 0);
    check("t3_no_ferr", fe_cnt, 0);

    // stop bit low, line held low, then recovery
    e0 = cyc;
    send_byte(8'h3C, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(20);
    check("t4_ferr_count", fe_cnt, 1);
    check("t4_ferr_time", fe_t - e0, 155);
    check("t4_no_valid", vq.size(), 0);
    check("t4_rx_data_kept", rx_data, 8'hA5);
    check("t4_busy_idle", busy, 1'b0);
    send_byte(8'h55, 1'b1);
    tick(4);
    check("t4_recover_count", vq.size(), 1);
    check("t4_recover_data", vq[0], 8'h55);

    // three frames with 1-bit stops
    vq.delete(); vt.delete();
    tick(5);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    tick(4);
    check("t5_count", vq.size(), 3);
    check("t5_byte0", vq[0], 8'h12);
    check("t5_byte1", vq[1], 8'h34);
    check("t5_byte2", vq[2], 8'h56);
    check("t5_gap01", vt[1] - vt[0], 160);
    check("t5_gap12", vt[2] - vt[1], 160);

    // reset in the middle of bit 4 of C3
    vq.delete(); vt.delete();
    tick(5);
    b = 8'hC3;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = b[4];
    tick(8);
    rst = 1'b1;
    tick(1);
    check("t6_rst_rx_data", rx_data, 8'h00);
    check("t6_rst_rx_valid", rx_valid, 1'b0);
    check("t6_rst_frame_err", frame_err, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_no_early_out", vq.size(), 0);
    rst = 1'b0;
    tick(7);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = 1'b1;
    tick(16);
    tick(120);
    send_byte(8'h7E, 1'b1);
    tick(4);
    found = 0;
    foreach (vq[i]) if (vq[i] == 8'hC3) found++;
    check("t6_no_c3", found, 0);
    check("t6_last_7e", vq[vq.size() - 1], 8'h7E);
    check("t6_rx_data", rx_data, 8'h7E);

    check("pulses_exclusive", both_cnt, 0);
    check("pulses_single_cycle", dbl_cnt, 0);
    check("total_ferr", fe_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
